// File: rtl/mvm_noc_arbiter.sv
// Round-robin packet arbiter that feeds the MVM NoC injection port. Whole packets are
// granted and each beat goes out through a single register stage, tagged with its source index.
module mvm_noc_arbiter #(
    parameter int NREQ  = 4,
    parameter int DATAW = 128,
    parameter int IDW   = 4,
    parameter int DESTW = 12,
    parameter int USERW = 75
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_tvalid,
    output logic [NREQ-1:0]        req_tready,
    input  logic [NREQ*DATAW-1:0]  req_tdata,
    input  logic [NREQ*DESTW-1:0]  req_tdest,
    input  logic [NREQ*USERW-1:0]  req_tuser,
    input  logic [NREQ-1:0]        req_tlast,
    output logic                   m_tvalid,
    output logic [DATAW-1:0]       m_tdata,
    output logic [DESTW-1:0]       m_tdest,
    output logic [USERW-1:0]       m_tuser,
    output logic                   m_tlast,
    output logic [IDW-1:0]         m_tid,
    input  logic                   m_tready,
    output logic                   busy
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

    logic               m_tvalid_q, m_tvalid_d;
    logic [DATAW-1:0]   m_tdata_q, m_tdata_d;
    logic [DESTW-1:0]   m_tdest_q, m_tdest_d;
    logic [USERW-1:0]   m_tuser_q, m_tuser_d;
    logic               m_tlast_q, m_tlast_d;
    logic [IDW-1:0]     m_tid_q, m_tid_d;

    logic               sel_valid_s;
    logic               sel_last_s;
    logic [DATAW-1:0]   sel_data_s;
    logic [DESTW-1:0]   sel_dest_s;
    logic [USERW-1:0]   sel_user_s;

    logic [IDW-1:0]     pick_hi_s;
    logic [IDW-1:0]     pick_lo_s;
    logic               found_hi_s;
    logic               any_valid_s;

    logic               out_ready_s;
    logic               accept_s;
    logic [NREQ-1:0]    req_tready_s;

    // Select the beat presented by the currently granted requester
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = {DATAW{1'b0}};
        sel_dest_s  = {DESTW{1'b0}};
        sel_user_s  = {USERW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_valid_s = (grant_q == IDW'(i)) ? req_tvalid[i]                : sel_valid_s;
            sel_last_s  = (grant_q == IDW'(i)) ? req_tlast[i]                 : sel_last_s;
            sel_data_s  = (grant_q == IDW'(i)) ? req_tdata[i*DATAW +: DATAW]  : sel_data_s;
            sel_dest_s  = (grant_q == IDW'(i)) ? req_tdest[i*DESTW +: DESTW]  : sel_dest_s;
            sel_user_s  = (grant_q == IDW'(i)) ? req_tuser[i*USERW +: USERW]  : sel_user_s;
        end
    end

    // Round-robin pick: lowest valid index above rr_ptr, otherwise lowest valid index at or below it
    always_comb begin
        pick_hi_s  = {IDW{1'b0}};
        pick_lo_s  = {IDW{1'b0}};
        found_hi_s = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            pick_hi_s  = (req_tvalid[i] && (IDW'(i) >  rr_ptr_q)) ? IDW'(i) : pick_hi_s;
            pick_lo_s  = (req_tvalid[i] && (IDW'(i) <= rr_ptr_q)) ? IDW'(i) : pick_lo_s;
            found_hi_s = found_hi_s | (req_tvalid[i] && (IDW'(i) > rr_ptr_q));
        end
        any_valid_s = |req_tvalid;
    end

    // Handshake toward the granted requester; ready follows the output register's space
    always_comb begin
        req_tready_s = {NREQ{1'b0}};
        out_ready_s  = !m_tvalid_q || m_tready;
        accept_s     = (state_q == ST_LOCKED) && sel_valid_s && out_ready_s;
        for (int i = 0; i < NREQ; i++) begin
            req_tready_s[i] = (state_q == ST_LOCKED) && (grant_q == IDW'(i)) && out_ready_s;
        end
    end

    // Next-state for the arbitration FSM and the output holding register
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tdest_d  = m_tdest_q;
        m_tuser_d  = m_tuser_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;

        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    state_d = ST_LOCKED;
                    grant_d = found_hi_s ? pick_hi_s : pick_lo_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                // No timeout: a stalled requester keeps the grant until its tlast goes through
                if (accept_s && sel_last_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_q;
                end else begin
                    state_d  = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = sel_data_s;
            m_tdest_d  = sel_dest_s;
            m_tuser_d  = sel_user_s;
            m_tlast_d  = sel_last_s;
            m_tid_d    = grant_q;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= {IDW{1'b0}};
            rr_ptr_q   <= IDW'(NREQ - 1);
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= {DATAW{1'b0}};
            m_tdest_q  <= {DESTW{1'b0}};
            m_tuser_q  <= {USERW{1'b0}};
            m_tlast_q  <= 1'b0;
            m_tid_q    <= {IDW{1'b0}};
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tdest_q  <= m_tdest_d;
            m_tuser_q  <= m_tuser_d;
            m_tlast_q  <= m_tlast_d;
            m_tid_q    <= m_tid_d;
        end
    end

    assign req_tready = req_tready_s;
    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign m_tdest    = m_tdest_q;
    assign m_tuser    = m_tuser_q;
    assign m_tlast    = m_tlast_q;
    assign m_tid      = m_tid_q;
    assign busy       = (state_q == ST_LOCKED) || m_tvalid_q;

endmodule

// File: tb/tb_mvm_noc_arbiter.sv
// Bench for mvm_noc_arbiter: packet-source queues, a transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed beat sequences.
module tb_mvm_noc_arbiter;

    localparam int NREQ  = 4;
    localparam int DATAW = 128;
    localparam int IDW   = 4;
    localparam int DESTW = 12;
    localparam int USERW = 75;

    typedef struct {
        logic [DATAW-1:0] data;
        logic [DESTW-1:0] dest;
        logic [USERW-1:0] user;
        logic             last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NREQ-1:0]       req_tvalid = '0;
    logic [NREQ-1:0]       req_tready;
    logic [NREQ*DATAW-1:0] req_tdata = '0;
    logic [NREQ*DESTW-1:0] req_tdest = '0;
    logic [NREQ*USERW-1:0] req_tuser = '0;
    logic [NREQ-1:0]       req_tlast = '0;
    logic                  m_tvalid;
    logic [DATAW-1:0]      m_tdata;
    logic [DESTW-1:0]      m_tdest;
    logic [USERW-1:0]      m_tuser;
    logic                  m_tlast;
    logic [IDW-1:0]        m_tid;
    logic                  m_tready = 1'b1;
    logic                  busy;

    mvm_noc_arbiter #(.NREQ(NREQ), .DATAW(DATAW), .IDW(IDW), .DESTW(DESTW), .USERW(USERW)) dut (
        .clk(clk), .reset(reset),
        .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
        .req_tdest(req_tdest), .req_tuser(req_tuser), .req_tlast(req_tlast),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .m_tid(m_tid), .m_tready(m_tready), .busy(busy)
    );

    always #5 clk = ~clk;

    beat_t           srcq [NREQ][$];
    logic [NREQ-1:0] en = '0;
    logic [NREQ-1:0] hs = '0;
    int              pops [NREQ];
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;

    // reference model: who owns the port (-1 = nobody), who was last served, what sits on m_*
    int              mod_owner = -1;
    int              mod_rr = NREQ - 1;
    logic            mod_v = 1'b0;
    beat_t           mod_b;
    int              mod_tid = 0;
    logic [NREQ-1:0] exp_rdy;
    logic            acc;

    int               dl_cyc [$];
    int               dl_tid [$];
    logic [DATAW-1:0] dl_data [$];
    logic [DESTW-1:0] dl_dest [$];
    logic             dl_last [$];
    int               dl_base = 0;

    task automatic chk(input string nm, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // first requester after 'last' (cyclically) that has a valid beat
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int d = 1; d <= NREQ; d++) begin
            if (v[(last + d) % NREQ]) return (last + d) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // compare DUT against the model every cycle, then advance the model on this cycle's inputs
    always @(negedge clk) begin
        if (reset) begin
            mod_owner = -1;
            mod_rr    = NREQ - 1;
            mod_v     = 1'b0;
            mod_tid   = 0;
            hs        = '0;
            chk("rst_req_tready", req_tready, '0);
            chk("rst_busy", busy, '0);
            chk("rst_m_tvalid", m_tvalid, '0);
            chk("rst_m_tlast", m_tlast, '0);
            chk("rst_m_tdata", m_tdata, '0);
            chk("rst_m_tdest", m_tdest, '0);
            chk("rst_m_tuser", m_tuser, '0);
            chk("rst_m_tid", m_tid, '0);
        end else begin
            exp_rdy = '0;
            if (mod_owner >= 0) exp_rdy[mod_owner] = !mod_v || m_tready;
            chk("req_tready", req_tready, exp_rdy);
            chk("busy", busy, (mod_owner >= 0) || mod_v);
            chk("m_tvalid", m_tvalid, mod_v);
            if (mod_v) begin
                chk("m_tdata", m_tdata, mod_b.data);
                chk("m_tdest", m_tdest, mod_b.dest);
                chk("m_tuser", m_tuser, mod_b.user);
                chk("m_tlast", m_tlast, mod_b.last);
                chk("m_tid", m_tid, mod_tid);
            end
            if (m_tvalid && m_tready) begin
                dl_cyc.push_back(cyc);
                dl_tid.push_back(int'(m_tid));
                dl_data.push_back(m_tdata);
                dl_dest.push_back(m_tdest);
                dl_last.push_back(m_tlast);
            end
            hs = req_tvalid & req_tready;
            acc = (mod_owner >= 0) && req_tvalid[mod_owner] && exp_rdy[mod_owner];
            if (acc) begin
                mod_b.data = req_tdata[mod_owner*DATAW +: DATAW];
                mod_b.dest = req_tdest[mod_owner*DESTW +: DESTW];
                mod_b.user = req_tuser[mod_owner*USERW +: USERW];
                mod_b.last = req_tlast[mod_owner];
                mod_v      = 1'b1;
                mod_tid    = mod_owner;
                if (mod_b.last) begin
                    mod_rr    = mod_owner;
                    mod_owner = -1;
                end
            end else begin
                if (m_tready) mod_v = 1'b0;
                if (mod_owner < 0) mod_owner = rr_pick(mod_rr, req_tvalid);
            end
        end
    end

    // packet sources: retire handshaken beats, then present the head of each enabled queue
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && srcq[i].size() > 0) begin
                srcq[i].delete(0);
                pops[i]++;
            end
            if (en[i] && srcq[i].size() > 0) begin
                req_tvalid[i]                 = 1'b1;
                req_tdata[i*DATAW +: DATAW]   = srcq[i][0].data;
                req_tdest[i*DESTW +: DESTW]   = srcq[i][0].dest;
                req_tuser[i*USERW +: USERW]   = srcq[i][0].user;
                req_tlast[i]                  = srcq[i][0].last;
            end else begin
                req_tvalid[i] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pkt(input int r, input int n, input int base, input int dest);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = DATAW'(base + k);
            b.dest = DESTW'(dest);
            b.user = USERW'((base + k) * 7 + 3);
            b.last = (k == n - 1);
            srcq[r].push_back(b);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_m_tvalid", m_tvalid, '0);
        chk("async_rst_req_tready", req_tready, '0);
        chk("async_rst_busy", busy, '0);
        for (int i = 0; i < NREQ; i++) begin
            srcq[i].delete();
            pops[i] = 0;
        end
        en = '0;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        dl_base = dl_data.size();
    endtask

    task automatic wait_dl(input int n, input string nm);
        int t = 0;
        while ((dl_data.size() - dl_base) < n && t < 200) begin
            tick();
            t++;
        end
        if ((dl_data.size() - dl_base) < n) timeout(nm);
    endtask

    task automatic wait_pops(input int r, input int n, input string nm);
        int t = 0;
        while (pops[r] < n && t < 100) begin
            tick();
            t++;
        end
        if (pops[r] < n) timeout(nm);
    endtask

    task automatic chk_beat(input string nm, input int idx, input int tid, input int data, input logic last);
        if (dl_base + idx < dl_data.size()) begin
            chk({nm, "_tid"}, dl_tid[dl_base + idx], tid);
            chk({nm, "_data"}, dl_data[dl_base + idx], data);
            chk({nm, "_last"}, dl_last[dl_base + idx], last);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: beat %0d missing", nm, idx);
        end
    endtask

    initial begin
        int n0;
        int t;
        logic [3:0] pat;
        pat = 4'b1001;
        #1 reset = 1'b1;
        do_reset();

        // 1: three-beat packet from requester 0, latency and tlast placement
        push_pkt(0, 3, 1, 5);
        en[0] = 1'b1;
        t = 0;
        while (!req_tvalid[0] && t < 20) begin
            tick();
            t++;
        end
        n0 = cyc;
        wait_dl(3, "t1_beats");
        for (int k = 0; k < 3; k++) begin
            chk_beat("t1", k, 0, k + 1, k == 2);
            if (dl_base + k < dl_data.size()) begin
                chk("t1_cycle", dl_cyc[dl_base + k], n0 + 2 + k);
                chk("t1_dest", dl_dest[dl_base + k], 5);
            end
        end
        while (cyc < n0 + 5) tick();
        chk("t1_busy_low", busy, 1'b0);

        // 2: four requesters, single-beat packets, strict rotation with one bubble
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++) push_pkt(i, 1, 16 * i + k, i);
        en = 4'b1111;
        wait_dl(8, "t2_beats");
        for (int j = 0; j < 8; j++) chk_beat("t2", j, j % 4, 16 * (j % 4) + j / 4, 1'b1);
        for (int j = 0; j < 7; j++)
            if (dl_base + j + 1 < dl_cyc.size())
                chk("t2_gap", dl_cyc[dl_base + j + 1] - dl_cyc[dl_base + j], 2);

        // 3: requester 2 holds the port through backpressure, requester 1 waits for its tlast
        do_reset();
        push_pkt(2, 4, 32, 2);
        en[2] = 1'b1;
        t = 0;
        while (!req_tready[2] && t < 20) begin
            tick();
            t++;
        end
        push_pkt(1, 2, 64, 1);
        en[1] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            m_tready = pat[k % 4];
            tick();
        end
        m_tready = 1'b1;
        wait_dl(6, "t3_beats");
        for (int k = 0; k < 4; k++) chk_beat("t3", k, 2, 32 + k, k == 3);
        for (int k = 0; k < 2; k++) chk_beat("t3", 4 + k, 1, 64 + k, k == 1);

        // 4: requester 3 goes quiet mid-packet; requester 0 must not be served meanwhile
        do_reset();
        push_pkt(3, 4, 48, 3);
        en[3] = 1'b1;
        wait_pops(3, 2, "t4_pops");
        en[3] = 1'b0;
        push_pkt(0, 1, 80, 0);
        en[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_ready0", req_tready[0], 1'b0);
            chk("t4_busy", busy, 1'b1);
        end
        en[3] = 1'b1;
        wait_dl(5, "t4_beats");
        for (int k = 0; k < 4; k++) chk_beat("t4", k, 3, 48 + k, k == 3);
        chk_beat("t4", 4, 0, 80, 1'b1);

        // 5: reset in the middle of a packet, then requester 0 wins over requester 1
        do_reset();
        push_pkt(2, 4, 96, 2);
        en[2] = 1'b1;
        wait_pops(2, 2, "t5_pops");
        do_reset();
        push_pkt(1, 1, 113, 1);
        push_pkt(0, 1, 112, 0);
        en = 4'b0011;
        wait_dl(2, "t5_beats");
        chk_beat("t5", 0, 0, 112, 1'b1);
        chk_beat("t5", 1, 1, 113, 1'b1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
